// File: rtl/layer_priority_ctrl.sv
// layer_priority_ctrl: per-pixel layer selection driven by a priority table.
// A shadow priority table is written through cfg_*, and it is copied to the
// active table at the next startOfFrame.
// Optional feature macro: LAYER_BLINK_EN. When it is defined, layers selected
// by blinkMask are suppressed during every other block of BLINK_FRAMES frames.
module layer_priority_ctrl #(
  parameter int unsigned LAYERS       = 6,
  parameter int unsigned BLINK_FRAMES = 8
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic [LAYERS-1:0]      layerDR,
  input  logic [LAYERS-1:0][7:0] layerRGB,
  input  logic [7:0]             backGroundRGB,
  input  logic                   cfg_valid,
  input  logic [2:0]             cfg_slot,
  input  logic [2:0]             cfg_layer,
  output logic                   cfg_ready,
  output logic                   cfg_err,
  output logic                   commitDone,
  input  logic [LAYERS-1:0]      blinkMask,
  output logic [7:0]             RGBOut,
  output logic [2:0]             winLayer,
  output logic                   anyHit
);

  typedef enum logic [1:0] {IDLE, DIRTY, COMMIT} state_t;

  state_t                 state;
  logic [LAYERS-1:0][2:0] active_tbl;
  logic [LAYERS-1:0][2:0] shadow_tbl;
  logic [LAYERS-1:0][2:0] shadow_nx;
  logic                   wr_acc;
  logic                   wr_bad;
  logic                   wr_ok;
  logic [LAYERS-1:0]      req_eff;
  logic [7:0]             req8;
  logic [7:0][7:0]        rgb8;
  logic                   found;
  logic [2:0]             win;

`ifdef LAYER_BLINK_EN
  logic [7:0] frame_cnt;
  logic       blink_phase;

  // Frame counter: toggles blink_phase every BLINK_FRAMES frame starts
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      frame_cnt   <= 8'd0;
      blink_phase <= 1'b0;
    end else if (startOfFrame) begin
      if (frame_cnt == 8'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= 8'd0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  assign req_eff = layerDR & ~(blink_phase ? blinkMask : '0);
`else
  logic unused_blink;

  assign unused_blink = ^{blinkMask, 8'(BLINK_FRAMES)};
  assign req_eff      = layerDR;
`endif

  // Config write decode; out-of-range writes are accepted but leave the shadow untouched
  always_comb begin
    wr_acc    = cfg_valid & cfg_ready;
    wr_bad    = ({1'b0, cfg_slot} >= 4'(LAYERS)) || ({1'b0, cfg_layer} >= 4'(LAYERS));
    wr_ok     = wr_acc & ~wr_bad;
    shadow_nx = shadow_tbl;
    if (wr_ok) begin
      for (int i = 0; i < int'(LAYERS); i++) begin
        if (cfg_slot == 3'(i)) shadow_nx[i] = cfg_layer;
      end
    end
  end

  // Config FSM; the active table loads on entry to COMMIT, so it includes a same-cycle write
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      cfg_ready  <= 1'b1;
      cfg_err    <= 1'b0;
      commitDone <= 1'b0;
      for (int i = 0; i < int'(LAYERS); i++) begin
        active_tbl[i] <= 3'(i);
        shadow_tbl[i] <= 3'(i);
      end
    end else begin
      cfg_err    <= wr_acc & wr_bad;
      commitDone <= 1'b0;
      cfg_ready  <= 1'b1;
      shadow_tbl <= shadow_nx;
      case (state)
        IDLE: begin
          if (wr_ok) state <= DIRTY;
        end
        DIRTY: begin
          if (startOfFrame) begin
            state      <= COMMIT;
            active_tbl <= shadow_nx;
            commitDone <= 1'b1;
            cfg_ready  <= 1'b0;
          end
        end
        COMMIT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Priority scan: the lowest slot whose layer requests wins
  always_comb begin
    req8  = 8'(req_eff);
    rgb8  = '0;
    found = 1'b0;
    win   = 3'd0;
    for (int i = 0; i < int'(LAYERS); i++) rgb8[i] = layerRGB[i];
    for (int i = 0; i < int'(LAYERS); i++) begin
      if (!found && req8[active_tbl[i]]) begin
        found = 1'b1;
        win   = active_tbl[i];
      end
    end
  end

  // Registered pixel output, falling back to the background colour
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      RGBOut   <= 8'd0;
      winLayer <= 3'd0;
      anyHit   <= 1'b0;
    end else begin
      RGBOut   <= found ? rgb8[win] : backGroundRGB;
      winLayer <= found ? win : 3'd0;
      anyHit   <= found;
    end
  end

endmodule

// File: tb/tb_layer_priority_ctrl.sv
// Directed testbench for layer_priority_ctrl (LAYERS=6, BLINK_FRAMES=2).
module tb_layer_priority_ctrl;

  localparam int unsigned LAYERS = 6;
  localparam int unsigned BF     = 2;

  logic                   clk = 1'b0;
  logic                   resetN;
  logic                   startOfFrame;
  logic [LAYERS-1:0]      layerDR;
  logic [LAYERS-1:0][7:0] layerRGB;
  logic [7:0]             backGroundRGB;
  logic                   cfg_valid;
  logic [2:0]             cfg_slot;
  logic [2:0]             cfg_layer;
  logic                   cfg_ready;
  logic                   cfg_err;
  logic                   commitDone;
  logic [LAYERS-1:0]      blinkMask;
  logic [7:0]             RGBOut;
  logic [2:0]             winLayer;
  logic                   anyHit;

  int n_vec = 0;
  int n_err = 0;

  layer_priority_ctrl #(.LAYERS(LAYERS), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .layerDR(layerDR), .layerRGB(layerRGB), .backGroundRGB(backGroundRGB),
    .cfg_valid(cfg_valid), .cfg_slot(cfg_slot), .cfg_layer(cfg_layer),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .commitDone(commitDone),
    .blinkMask(blinkMask), .RGBOut(RGBOut), .winLayer(winLayer), .anyHit(anyHit)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input logic [2:0] slot, input logic [2:0] layer);
    cfg_valid = 1'b1;
    cfg_slot  = slot;
    cfg_layer = layer;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    tick();
    tick();
    resetN = 1'b1;
  endtask

  initial begin
    resetN        = 1'b0;
    startOfFrame  = 1'b0;
    layerDR       = '0;
    layerRGB[0]   = 8'h03;
    layerRGB[1]   = 8'h1C;
    layerRGB[2]   = 8'hE0;
    layerRGB[3]   = 8'h0F;
    layerRGB[4]   = 8'h55;
    layerRGB[5]   = 8'hAA;
    backGroundRGB = 8'h49;
    cfg_valid     = 1'b0;
    cfg_slot      = 3'd0;
    cfg_layer     = 3'd0;
    blinkMask     = '0;
    tick();
    tick();

    // reset values
    chk("rst_rgb", 32'(RGBOut), 32'h00);
    chk("rst_win", 32'(winLayer), 32'd0);
    chk("rst_hit", 32'(anyHit), 32'd0);
    chk("rst_err", 32'(cfg_err), 32'd0);
    chk("rst_done", 32'(commitDone), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    resetN = 1'b1;

    // identity table: layer 1 beats layer 2
    layerDR = 6'b000110;
    tick();
    chk("id_rgb", 32'(RGBOut), 32'h1C);
    chk("id_win", 32'(winLayer), 32'd1);
    chk("id_hit", 32'(anyHit), 32'd1);

    // no requests -> background
    layerDR = 6'b000000;
    tick();
    chk("bg_rgb", 32'(RGBOut), 32'h49);
    chk("bg_win", 32'(winLayer), 32'd0);
    chk("bg_hit", 32'(anyHit), 32'd0);
    layerDR = 6'b000110;

    // slot0=2 stays in shadow until a frame start
    write_cfg(3'd0, 3'd2);
    tick();
    cfg_valid = 1'b0;
    tick();
    chk("pend_rgb", 32'(RGBOut), 32'h1C);
    chk("pend_done", 32'(commitDone), 32'd0);
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    chk("cm_ready", 32'(cfg_ready), 32'd0);
    chk("cm_done", 32'(commitDone), 32'd1);
    chk("cm_rgb_old", 32'(RGBOut), 32'h1C);
    tick();
    chk("post_ready", 32'(cfg_ready), 32'd1);
    chk("post_done", 32'(commitDone), 32'd0);
    chk("post_rgb", 32'(RGBOut), 32'hE0);
    chk("post_win", 32'(winLayer), 32'd2);

    // out-of-range writes: err pulse, no state change
    write_cfg(3'd6, 3'd0);
    tick();
    chk("oor_slot_err", 32'(cfg_err), 32'd1);
    write_cfg(3'd0, 3'd7);
    tick();
    chk("oor_layer_err", 32'(cfg_err), 32'd1);
    cfg_valid = 1'b0;
    tick();
    chk("oor_err_clr", 32'(cfg_err), 32'd0);
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    chk("oor_no_commit", 32'(commitDone), 32'd0);
    chk("oor_ready", 32'(cfg_ready), 32'd1);
    tick();
    chk("oor_rgb", 32'(RGBOut), 32'hE0);

    // write in the same cycle as the committing frame start is included
    layerDR = 6'b010110;
    write_cfg(3'd0, 3'd1);
    tick();
    write_cfg(3'd0, 3'd4);
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    chk("same_done", 32'(commitDone), 32'd1);
    // held cfg_valid during COMMIT must be refused
    write_cfg(3'd0, 3'd1);
    tick();
    cfg_valid = 1'b0;
    chk("same_rgb", 32'(RGBOut), 32'h55);
    chk("same_win", 32'(winLayer), 32'd4);
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    chk("commit_wr_refused", 32'(commitDone), 32'd0);

    // table now 4,1,2,3,4,5: layer 0 absent, layer 4 duplicated
    layerDR = 6'b000001;
    tick();
    chk("absent_hit", 32'(anyHit), 32'd0);
    chk("absent_rgb", 32'(RGBOut), 32'h49);
    layerDR = 6'b010000;
    tick();
    chk("dup_win", 32'(winLayer), 32'd4);
    chk("dup_rgb", 32'(RGBOut), 32'h55);

    // reset while DIRTY discards the pending write
    write_cfg(3'd0, 3'd3);
    tick();
    cfg_valid = 1'b0;
    do_reset();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    chk("rstd_no_done", 32'(commitDone), 32'd0);
    layerDR = 6'b111111;
    tick();
    chk("rstd_win", 32'(winLayer), 32'd0);
    chk("rstd_rgb", 32'(RGBOut), 32'h03);
    chk("rstd_hit", 32'(anyHit), 32'd1);

    // blink: layer 1 masked, layers 1 and 2 requesting
    do_reset();
    layerDR   = 6'b000110;
    blinkMask = 6'b000010;
    tick();
    chk("blink_f0", 32'(winLayer), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      logic [2:0] exp_win;
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick();
`ifdef LAYER_BLINK_EN
      exp_win = (((k / int'(BF)) % 2) == 1) ? 3'd2 : 3'd1;
`else
      exp_win = 3'd1;
`endif
      chk($sformatf("blink_f%0d", k), 32'(winLayer), 32'(exp_win));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/layer_priority_ctrl.md
LAYER_PRIORITY_CTRL -- requirements
Module: layer_priority_ctrl

Interface
REQ-001 The block SHALL have parameter LAYERS, default 6, the number of drawable layers (2..8).
REQ-002 The block SHALL have parameter BLINK_FRAMES, default 8, the frames per blink half-period (1..255).
REQ-003 The block SHALL have port clk  in  1  system clock.
REQ-004 The block SHALL have port resetN  in  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port startOfFrame  in  1  one-cycle pulse at frame start.
REQ-006 The block SHALL have port layerDR  in  LAYERS  per-layer drawing request.
REQ-007 The block SHALL have port layerRGB  in  LAYERS x 8  per-layer pixel colour.
REQ-008 The block SHALL have port backGroundRGB  in  8  colour used when no layer wins.
REQ-009 The block SHALL have port cfg_valid  in  1  priority-write request.
REQ-010 The block SHALL have port cfg_slot  in  3  priority slot to write; 0 is highest priority.
REQ-011 The block SHALL have port cfg_layer  in  3  layer index to place in the slot.
REQ-012 The block SHALL have port cfg_ready  out  1  write accepted when high with cfg_valid.
REQ-013 The block SHALL have port cfg_err  out  1  one-cycle pulse on an accepted write with cfg_slot or cfg_layer >= LAYERS.
REQ-014 The block SHALL have port commitDone  out  1  one-cycle pulse when the shadow table becomes active.
REQ-015 The block SHALL have port blinkMask  in  LAYERS  layers subject to blinking.
REQ-016 The block SHALL have port RGBOut  out  8  registered pixel colour.
REQ-017 The block SHALL have port winLayer  out  3  registered winning layer index.
REQ-018 The block SHALL have port anyHit  out  1  registered; high when a layer won.

Function
REQ-019 Pixel path: the block SHALL scan active slots 0..LAYERS-1; the first slot whose layer has an unsuppressed layerDR wins, and the result is registered with 1-cycle latency.
REQ-020 No winner: RGBOut SHALL equal backGroundRGB, winLayer 0, anyHit 0.
REQ-021 Duplicate layer entries in the table SHALL be legal; the lowest matching slot wins, and a layer absent from the table never wins.
REQ-022 Config FSM states SHALL be IDLE, DIRTY, COMMIT; an accepted write goes IDLE->DIRTY; DIRTY stays DIRTY on writes.
REQ-023 DIRTY with startOfFrame SHALL go to COMMIT; COMMIT copies shadow to active, pulses commitDone, then goes to IDLE.
REQ-024 startOfFrame in IDLE SHALL cause no commit and no commitDone.
REQ-025 cfg_ready SHALL be 0 in COMMIT and 1 otherwise.
REQ-026 A write accepted in the same cycle as the startOfFrame that triggers COMMIT SHALL be included in that commit.
REQ-027 Out-of-range writes SHALL be accepted, SHALL leave the shadow unchanged, SHALL pulse cfg_err, and SHALL NOT change FSM state.
REQ-028 Active-table changes SHALL first affect RGBOut on the cycle after COMMIT.

Reset
REQ-029 On resetN low, RGBOut, winLayer, anyHit, cfg_err and commitDone SHALL be 0, the state SHALL be IDLE, and the frame counter and blinkPhase SHALL be 0.
REQ-030 On reset, the active and shadow tables SHALL both be set so that slot i holds layer i.
REQ-031 Reset asserted mid-DIRTY SHALL discard pending writes.

Configuration
REQ-032 With LAYER_BLINK_EN defined, a frame counter SHALL count startOfFrame pulses and toggle blinkPhase, then clear, each time it reaches BLINK_FRAMES.
REQ-033 While blinkPhase=1, layers with blinkMask set SHALL be treated as not requesting.
REQ-034 Without LAYER_BLINK_EN, the block SHALL have no counter, and blinkMask SHALL be ignored.

Verification
REQ-035 After reset, with layerDR=6'b000110, layerRGB[1]=8'h1C and layerRGB[2]=8'hE0 -> next cycle RGBOut=8'h1C, winLayer=1, anyHit=1.
REQ-036 Write slot0=2 in IDLE, no startOfFrame -> RGBOut still layer 1; after startOfFrame, one COMMIT cycle with cfg_ready=0 and commitDone=1, then RGBOut=8'hE0, winLayer=2.
REQ-037 Write slot 6 or layer 7 with LAYERS=6 -> cfg_err pulses for 1 cycle, state stays IDLE, and no commit occurs at the next startOfFrame.
REQ-038 layerDR=0 with backGroundRGB=8'h49 -> RGBOut=8'h49, anyHit=0.
REQ-039 With LAYER_BLINK_EN, BLINK_FRAMES=2, blinkMask=6'b000010 and layers 1 and 2 requesting -> winner alternates 1,2 every 2 frames.
REQ-040 Assert resetN low while in DIRTY -> table returns to identity and no commitDone occurs at the next startOfFrame.
